// File: rtl/sobel_pkg.sv
// Shared defaults for the Sobel 3x3 window generator.
// Optional feature macro: WIN_COORD_EN (adds win_x/win_y centre coordinate outputs).
package sobel_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int PIX_W_DEF = 8;

    localparam int COL_W = $clog2(IMG_W_DEF);
    localparam int ROW_W = $clog2(IMG_H_DEF);

endpackage

// File: rtl/sobel_line_buf.sv
// Single-port line memory with synchronous read-before-write.
// The read port returns the word stored before a same-address write; the
// output register only moves on enabled cycles, so it holds between accepts.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = COL_W
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;

    // Block-RAM style port: registered read of the old word, optional write.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
            end
            r_dout <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 window generator feeding SobelFilter from a raster-order pixel stream.
// Optional feature macro: WIN_COORD_EN (adds win_x/win_y centre coordinates).
//
// Stream handshake: pix_valid alone qualifies pix_in and sof; there is no
// ready, so every cycle with pix_valid=1 is an accept and nothing is dropped.
// Outputs are registered: win_valid/frame_done pulse on the cycle after the
// accept that caused them, and are 0 on every cycle that follows a non-accept.
//
// The two previous lines live in a ping-pong pair of single-port RAMs: even
// rows are written into ram0, odd rows into ram1. While row r is streaming,
// the RAM of r's parity still holds row r-2 (read before being overwritten)
// and the other RAM holds row r-1. This gives the lb1/lb2 line-delay
// behaviour without needing a same-cycle read-modify-write between memories.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output logic [PIX_W-1:0]         lu,
    output logic [PIX_W-1:0]         cu,
    output logic [PIX_W-1:0]         ru,
    output logic [PIX_W-1:0]         lc,
    output logic [PIX_W-1:0]         cc,
    output logic [PIX_W-1:0]         rc,
    output logic [PIX_W-1:0]         lb,
    output logic [PIX_W-1:0]         cb,
    output logic [PIX_W-1:0]         rb,
    output logic                     win_valid,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y,
`endif
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_lu, r_cu, r_lc, r_cc, r_lb, r_cb, r_rb;
    logic             r_win_valid;
    logic             r_frame_done;
    logic             r_sel;
    logic             r_primed;

    logic             w_accept;
    logic [CW-1:0]    w_col_eff;
    logic [RW-1:0]    w_row_eff;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_we0;
    logic             w_we1;
    logic [PIX_W-1:0] w_dout0;
    logic [PIX_W-1:0] w_dout1;
    logic [PIX_W-1:0] w_ru;
    logic [PIX_W-1:0] w_rc;

    // sof forces the accepted pixel to (0,0) whatever the counters say.
    assign w_accept   = pix_valid;
    assign w_col_eff  = sof ? '0 : r_col;
    assign w_row_eff  = sof ? '0 : r_row;
    assign w_last_col = (w_col_eff == CW'(IMG_W - 1));
    assign w_last_row = (w_row_eff == RW'(IMG_H - 1));
    assign w_we0      = w_accept & ~w_row_eff[0];
    assign w_we1      = w_accept &  w_row_eff[0];

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_ram0 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_we   (w_we0),
        .i_addr (w_col_eff),
        .i_din  (pix_in),
        .o_dout (w_dout0)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_ram1 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_we   (w_we1),
        .i_addr (w_col_eff),
        .i_din  (pix_in),
        .o_dout (w_dout1)
    );

    // Right column from the RAMs: row r-2 sits in the RAM of r's parity.
    // Until the first accept after reset the RAM registers are undefined,
    // so the taps are forced to 0 to give a clean reset value.
    assign w_ru = r_primed ? (r_sel ? w_dout1 : w_dout0) : '0;
    assign w_rc = r_primed ? (r_sel ? w_dout0 : w_dout1) : '0;

    // Column/row raster counters with end-of-line and end-of-frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row_eff + RW'(1);
            end else begin
                r_col <= w_col_eff + CW'(1);
                r_row <= w_row_eff;
            end
        end
    end

    // Window shift: every accept moves the columns one step to the left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu     <= '0;
            r_cu     <= '0;
            r_lc     <= '0;
            r_cc     <= '0;
            r_lb     <= '0;
            r_cb     <= '0;
            r_rb     <= '0;
            r_sel    <= 1'b0;
            r_primed <= 1'b0;
        end else if (w_accept) begin
            r_lu     <= r_cu;
            r_cu     <= w_ru;
            r_lc     <= r_cc;
            r_cc     <= w_rc;
            r_lb     <= r_cb;
            r_cb     <= r_rb;
            r_rb     <= pix_in;
            r_sel    <= w_row_eff[0];
            r_primed <= 1'b1;
        end
    end

    // Strobes: window valid only for full 3x3 neighbourhoods, end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_accept && (w_row_eff >= RW'(2)) && (w_col_eff >= CW'(2));
            r_frame_done <= w_accept && w_last_row && w_last_col;
        end
    end

`ifdef WIN_COORD_EN
    logic [CW-1:0] r_win_x;
    logic [RW-1:0] r_win_y;

    // Centre coordinates of the window, updated together with the taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_x <= '0;
            r_win_y <= '0;
        end else if (w_accept) begin
            r_win_x <= w_col_eff - CW'(1);
            r_win_y <= w_row_eff - RW'(1);
        end
    end

    assign win_x = r_win_x;
    assign win_y = r_win_y;
`endif

    assign lu         = r_lu;
    assign cu         = r_cu;
    assign ru         = w_ru;
    assign lc         = r_lc;
    assign cc         = r_cc;
    assign rc         = w_rc;
    assign lb         = r_lb;
    assign cb         = r_cb;
    assign rb         = r_rb;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule
